wb_spi_slave: RTL and testbench

Wishbone-mapped SPI responder (mode 0, 8-bit frames, MSB first) for the LM32 SoC, the target-side counterpart of the SPI master peripheral. An external SPI master clocks bytes in and out while the CPU reads received bytes and queues reply bytes through four word registers. Sits as one Wishbone slave on the conbus alongside the other peripherals and drives one interrupt line into the CPU interrupt vector.

---
 rtl/wb_spi_slave.sv | 370 +++++++++++++++++++++++++++++++++++++
 tb/tb_wb_spi_slave.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_spi_slave.sv
// wb_spi_slave: Wishbone-mapped SPI responder (mode 0, 8-bit, MSB first).
// An external master shifts bytes in and out; the CPU reads received bytes
// and queues reply bytes through RXDATA/TXDATA/STATUS/CTRL word registers.
// All SPI inputs are resynchronised into clk; the transfer engine is a small
// IDLE/LOAD/SHIFT/DONE state machine driven by detected SCK/SS_n edges.

module wb_spi_slave #(
    parameter int         sync_stages = 2,
    parameter logic [7:0] idle_byte   = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic        intr,
    input  logic        spi_sck_i,
    input  logic        spi_ss_n_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    output logic        spi_miso_oe
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [sync_stages-1:0] sck_sync_r;
    logic [sync_stages-1:0] ss_sync_r;
    logic [sync_stages-1:0] mosi_sync_r;
    logic                   sck_prev_r;
    logic                   ss_prev_r;

    logic sck_s;
    logic ss_s;
    logic ss_nx_s;
    logic mosi_s;
    logic sck_rise_s;
    logic sck_fall_s;
    logic ss_fall_s;

    assign sck_s      = sck_sync_r[sync_stages-1];
    assign ss_s       = ss_sync_r[sync_stages-1];
    // Value the synchronised SS_n will take after the next edge; lets the
    // registered outputs track "selected" without an extra cycle of lag.
    assign ss_nx_s    = ss_sync_r[sync_stages-2];
    assign mosi_s     = mosi_sync_r[sync_stages-1];
    assign sck_rise_s = sck_s & ~sck_prev_r;
    assign sck_fall_s = ~sck_s & sck_prev_r;
    assign ss_fall_s  = ~ss_s & ss_prev_r;

    // Shift the asynchronous SPI pins through the synchroniser chains.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync_r  <= {sync_stages{1'b0}};
            ss_sync_r   <= {sync_stages{1'b1}};
            mosi_sync_r <= {sync_stages{1'b0}};
            sck_prev_r  <= 1'b0;
            ss_prev_r   <= 1'b1;
        end else begin
            sck_sync_r  <= {sck_sync_r[sync_stages-2:0], spi_sck_i};
            ss_sync_r   <= {ss_sync_r[sync_stages-2:0], spi_ss_n_i};
            mosi_sync_r <= {mosi_sync_r[sync_stages-2:0], spi_mosi_i};
            sck_prev_r  <= sck_s;
            ss_prev_r   <= ss_s;
        end
    end

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    state_t      state_r;
    state_t      state_nx;
    logic [3:0]  bitcnt_r;
    logic [7:0]  rx_shift_r;
    logic [7:0]  tx_shift_r;
    logic [7:0]  rx_data_r;
    logic [7:0]  tx_buf_r;
    logic        rx_avail_r;
    logic        tx_empty_r;
    logic        overrun_r;
    logic        underrun_r;
    logic        en_r;
    logic        rx_ie_r;
    logic        tx_ie_r;
    logic        ack_r;
    logic [31:0] dat_o_r;
    logic        intr_r;
    logic        miso_oe_r;

    // ------------------------------------------------------------------
    // Wishbone decode: the request is seen with ack low, side effects
    // happen on the cycle ack is high.
    // ------------------------------------------------------------------
    logic        acc_s;
    logic        eff_s;
    logic        rd_rx_s;
    logic        wr_tx_s;
    logic        wr_stat_s;
    logic        wr_ctrl_s;
    logic [31:0] rdata_s;
    logic        unused_s;

    assign acc_s     = wb_stb_i & wb_cyc_i & ~ack_r;
    assign eff_s     = wb_stb_i & wb_cyc_i & ack_r;
    assign rd_rx_s   = eff_s & ~wb_we_i & (wb_adr_i[3:2] == 2'd0);
    assign wr_tx_s   = eff_s &  wb_we_i & (wb_adr_i[3:2] == 2'd1);
    assign wr_stat_s = eff_s &  wb_we_i & (wb_adr_i[3:2] == 2'd2);
    assign wr_ctrl_s = eff_s &  wb_we_i & (wb_adr_i[3:2] == 2'd3);
    assign unused_s  = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8]};

    // Select the read data for the addressed register.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (wb_adr_i[3:2])
            2'd0:    rdata_s = {24'h00_0000, rx_data_r};
            2'd1:    rdata_s = 32'h0000_0000;
            2'd2:    rdata_s = {27'd0, ~ss_s, underrun_r, overrun_r, tx_empty_r, rx_avail_r};
            2'd3:    rdata_s = {29'd0, tx_ie_r, rx_ie_r, en_r};
            default: rdata_s = 32'h0000_0000;
        endcase
    end

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    logic active_s;
    assign active_s = en_r & ~ss_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // FSM next-state logic; deselect or disable always returns to IDLE.
    always_comb begin
        state_nx = state_r;
        if (!active_s) begin
            state_nx = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ss_fall_s) begin
                        state_nx = ST_LOAD;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_LOAD:  state_nx = ST_SHIFT;
                ST_SHIFT: begin
                    if (sck_rise_s && (bitcnt_r == 4'd7)) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_SHIFT;
                    end
                end
                ST_DONE:  state_nx = ST_SHIFT;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    logic load_s;
    logic capture_s;
    logic shift_in_s;
    logic shift_out_s;
    logic clr_cnt_s;

    // FSM action decode: which datapath operations fire this cycle.
    always_comb begin
        load_s      = 1'b0;
        capture_s   = 1'b0;
        shift_in_s  = 1'b0;
        shift_out_s = 1'b0;
        clr_cnt_s   = 1'b0;
        if (!active_s) begin
            clr_cnt_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE:  clr_cnt_s = 1'b1;
                ST_LOAD:  load_s    = 1'b1;
                ST_SHIFT: begin
                    shift_in_s  = sck_rise_s;
                    shift_out_s = sck_fall_s & (bitcnt_r != 4'd0);
                end
                ST_DONE: begin
                    capture_s = 1'b1;
                    load_s    = 1'b1;
                end
                default:  clr_cnt_s = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Flag and control next-state values
    // ------------------------------------------------------------------
    logic rx_avail_nx;
    logic tx_empty_nx;
    logic overrun_nx;
    logic underrun_nx;
    logic en_nx;
    logic rx_ie_nx;
    logic tx_ie_nx;
    logic intr_nx;

    // Compute next flag/control values; hardware events win over CPU clears.
    always_comb begin
        rx_avail_nx = rx_avail_r;
        tx_empty_nx = tx_empty_r;
        overrun_nx  = overrun_r;
        underrun_nx = underrun_r;
        en_nx       = en_r;
        rx_ie_nx    = rx_ie_r;
        tx_ie_nx    = tx_ie_r;

        if (capture_s) begin
            rx_avail_nx = 1'b1;
        end else if (rd_rx_s) begin
            rx_avail_nx = 1'b0;
        end else begin
            rx_avail_nx = rx_avail_r;
        end

        // A read landing on the capture cycle consumed the old byte, so the
        // new one is not an overrun.
        if (capture_s && rx_avail_r && !rd_rx_s) begin
            overrun_nx = 1'b1;
        end else if (wr_stat_s && wb_dat_i[2]) begin
            overrun_nx = 1'b0;
        end else begin
            overrun_nx = overrun_r;
        end

        if (load_s) begin
            tx_empty_nx = 1'b1;
        end else if (wr_tx_s) begin
            tx_empty_nx = 1'b0;
        end else begin
            tx_empty_nx = tx_empty_r;
        end

        if (load_s && tx_empty_r && !wr_tx_s) begin
            underrun_nx = 1'b1;
        end else if (wr_stat_s && wb_dat_i[3]) begin
            underrun_nx = 1'b0;
        end else begin
            underrun_nx = underrun_r;
        end

        if (wr_ctrl_s) begin
            en_nx    = wb_dat_i[0];
            rx_ie_nx = wb_dat_i[1];
            tx_ie_nx = wb_dat_i[2];
        end else begin
            en_nx    = en_r;
            rx_ie_nx = rx_ie_r;
            tx_ie_nx = tx_ie_r;
        end

        intr_nx = (rx_ie_nx & rx_avail_nx) | (tx_ie_nx & tx_empty_nx & ~ss_nx_s);
    end

    // Flags, control bits and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_avail_r <= 1'b0;
            tx_empty_r <= 1'b1;
            overrun_r  <= 1'b0;
            underrun_r <= 1'b0;
            en_r       <= 1'b0;
            rx_ie_r    <= 1'b0;
            tx_ie_r    <= 1'b0;
            intr_r     <= 1'b0;
            miso_oe_r  <= 1'b0;
            ack_r      <= 1'b0;
            dat_o_r    <= 32'h0000_0000;
        end else begin
            rx_avail_r <= rx_avail_nx;
            tx_empty_r <= tx_empty_nx;
            overrun_r  <= overrun_nx;
            underrun_r <= underrun_nx;
            en_r       <= en_nx;
            rx_ie_r    <= rx_ie_nx;
            tx_ie_r    <= tx_ie_nx;
            intr_r     <= intr_nx;
            miso_oe_r  <= ~ss_nx_s & en_nx;
            ack_r      <= acc_s;
            if (acc_s && !wb_we_i) begin
                dat_o_r <= rdata_s;
            end else begin
                dat_o_r <= 32'h0000_0000;
            end
        end
    end

    // Shift datapath: bit counter, receive/transmit shifters, data buffers.
    always_ff @(posedge clk) begin
        if (reset) begin
            bitcnt_r   <= 4'd0;
            rx_shift_r <= 8'h00;
            tx_shift_r <= 8'h00;
            rx_data_r  <= 8'h00;
            tx_buf_r   <= 8'h00;
        end else begin
            if (clr_cnt_s || load_s) begin
                bitcnt_r <= 4'd0;
            end else if (shift_in_s) begin
                bitcnt_r <= bitcnt_r + 4'd1;
            end else begin
                bitcnt_r <= bitcnt_r;
            end

            if (shift_in_s) begin
                rx_shift_r <= {rx_shift_r[6:0], mosi_s};
            end else begin
                rx_shift_r <= rx_shift_r;
            end

            if (capture_s) begin
                rx_data_r <= rx_shift_r;
            end else begin
                rx_data_r <= rx_data_r;
            end

            // A TXDATA write on the load cycle goes straight to the shifter.
            if (load_s) begin
                if (wr_tx_s) begin
                    tx_shift_r <= wb_dat_i[7:0];
                end else if (tx_empty_r) begin
                    tx_shift_r <= idle_byte;
                end else begin
                    tx_shift_r <= tx_buf_r;
                end
            end else if (shift_out_s) begin
                tx_shift_r <= {tx_shift_r[6:0], 1'b0};
            end else begin
                tx_shift_r <= tx_shift_r;
            end

            if (wr_tx_s) begin
                tx_buf_r <= wb_dat_i[7:0];
            end else begin
                tx_buf_r <= tx_buf_r;
            end
        end
    end

    assign wb_ack_o    = ack_r;
    assign wb_dat_o    = dat_o_r;
    assign intr        = intr_r;
    assign spi_miso_o  = tx_shift_r[7];
    assign spi_miso_oe = miso_oe_r;

endmodule

// File: tb/tb_wb_spi_slave.sv
// Directed testbench for wb_spi_slave: Wishbone register access, SPI mode-0
// master model at eight clk per SCK phase, flags, interrupts, abort and the
// read/capture collision cycle.

module tb_wb_spi_slave;

    logic        clk;
    logic        reset;
    logic [31:0] wb_adr;
    logic [31:0] wb_wdat;
    logic [31:0] wb_rdat;
    logic [3:0]  wb_sel;
    logic        wb_stb;
    logic        wb_cyc;
    logic        wb_we;
    logic        wb_ack;
    logic        intr;
    logic        spi_sck;
    logic        spi_ss_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;

    int total;
    int bad;

    logic [31:0] rd;
    logic [7:0]  mi;
    logic        intr_at_ack;
    logic        intr_n3;
    logic        intr_n4;
    logic        coll_ack;
    logic [31:0] coll_dat;

    localparam logic [31:0] A_RX   = 32'h0000_0000;
    localparam logic [31:0] A_TX   = 32'h0000_0004;
    localparam logic [31:0] A_STAT = 32'h0000_0008;
    localparam logic [31:0] A_CTRL = 32'h0000_000C;

    wb_spi_slave #(.sync_stages(2), .idle_byte(8'h00)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_adr_i    (wb_adr),
        .wb_dat_i    (wb_wdat),
        .wb_dat_o    (wb_rdat),
        .wb_sel_i    (wb_sel),
        .wb_stb_i    (wb_stb),
        .wb_cyc_i    (wb_cyc),
        .wb_we_i     (wb_we),
        .wb_ack_o    (wb_ack),
        .intr        (intr),
        .spi_sck_i   (spi_sck),
        .spi_ss_n_i  (spi_ss_n),
        .spi_mosi_i  (spi_mosi),
        .spi_miso_o  (spi_miso),
        .spi_miso_oe (spi_miso_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                             output logic [31:0] rdat);
        int n;
        @(negedge clk);
        wb_adr  = adr;
        wb_we   = we;
        wb_wdat = wdat;
        wb_stb  = 1'b1;
        wb_cyc  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_ack && n < 20);
        check("wb_ack_seen", 32'(wb_ack), 32'd1);
        rdat        = wb_rdat;
        intr_at_ack = intr;
        @(negedge clk);
        wb_stb = 1'b0;
        wb_cyc = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] adr, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_access(adr, 1'b1, wdat, dummy);
    endtask

    task automatic ss_low();
        spi_ss_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (8) @(negedge clk);
        spi_ss_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Mode-0 master: drive MOSI while SCK low, sample MISO at the rising edge.
    task automatic spi_byte(input logic [7:0] mo, input int nbits, input bit collide,
                            output logic [7:0] mi_o);
        mi_o = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = mo[i];
            repeat (8) @(negedge clk);
            mi_o[i] = spi_miso;
            spi_sck = 1'b1;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                if (i == 0) begin
                    if (k == 2 && collide) begin
                        wb_adr = A_RX;
                        wb_we  = 1'b0;
                        wb_stb = 1'b1;
                        wb_cyc = 1'b1;
                    end
                    if (k == 3) begin
                        intr_n3  = intr;
                        coll_ack = wb_ack;
                        coll_dat = wb_rdat;
                    end
                    if (k == 4) begin
                        intr_n4 = intr;
                        if (collide) begin
                            wb_stb = 1'b0;
                            wb_cyc = 1'b0;
                        end
                    end
                end
            end
            spi_sck = 1'b0;
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        wb_adr = 32'h0; wb_wdat = 32'h0; wb_sel = 4'hF;
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        spi_sck = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_intr", 32'(intr), 32'd0);
        check("rst_oe", 32'(spi_miso_oe), 32'd0);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_ack", 32'(wb_ack), 32'd0);
        check("rst_dat", wb_rdat, 32'd0);
        wb_access(A_STAT, 1'b0, 32'h0, rd); check("rst_status", rd, 32'h0000_0002);
        wb_access(A_CTRL, 1'b0, 32'h0, rd); check("rst_ctrl", rd, 32'h0000_0000);

        // Single byte: reply 0xA5, receive 0x3C
        wb_wr(A_CTRL, 32'h1);
        wb_wr(A_TX, 32'hA5);
        wb_access(A_STAT, 1'b0, 32'h0, rd); check("tx_queued_status", rd, 32'h0000_0000);
        wb_access(A_TX, 1'b0, 32'h0, rd);   check("txdata_reads_0", rd, 32'h0000_0000);
        wb_access(A_CTRL, 1'b0, 32'h0, rd); check("ctrl_en", rd, 32'h0000_0001);
        ss_low();
        check("oe_selected", 32'(spi_miso_oe), 32'd1);
        wb_access(A_STAT, 1'b0, 32'h0, rd); check("loaded_status", rd, 32'h0000_0012);
        spi_byte(8'h3C, 8, 1'b0, mi);
        check("single_miso", 32'(mi), 32'h0000_00A5);
        wb_access(A_STAT, 1'b0, 32'h0, rd); check("single_status_sel", rd, 32'h0000_001B);
        ss_high();
        check("oe_deselected", 32'(spi_miso_oe), 32'd0);
        wb_access(A_STAT, 1'b0, 32'h0, rd); check("single_status", rd, 32'h0000_000B);
        wb_access(A_RX, 1'b0, 32'h0, rd);   check("single_rx", rd, 32'h0000_003C);
        wb_access(A_STAT, 1'b0, 32'h0, rd); check("status_after_read", rd, 32'h0000_000A);
        wb_wr(A_STAT, 32'h8);
        wb_access(A_STAT, 1'b0, 32'h0, rd); check("underrun_w1c", rd, 32'h0000_0002);

        // Back-to-back bytes without a CPU read
        wb_wr(A_TX, 32'h96);
        ss_low();
        spi_byte(8'h11, 8, 1'b0, mi); check("b2b_miso0", 32'(mi), 32'h0000_0096);
        spi_byte(8'h22, 8, 1'b0, mi); check("b2b_miso1_idle", 32'(mi), 32'h0000_0000);
        ss_high();
        wb_access(A_STAT, 1'b0, 32'h0, rd); check("b2b_status", rd, 32'h0000_000F);
        wb_access(A_RX, 1'b0, 32'h0, rd);   check("b2b_rx", rd, 32'h0000_0022);
        wb_wr(A_STAT, 32'hC);
        wb_access(A_STAT, 1'b0, 32'h0, rd); check("b2b_w1c", rd, 32'h0000_0002);

        // Abort after five bits, then a full frame
        wb_wr(A_TX, 32'hC3);
        ss_low();
        spi_byte(8'hFF, 5, 1'b0, mi); check("abort_miso", 32'(mi), 32'h0000_00C0);
        ss_high();
        wb_access(A_STAT, 1'b0, 32'h0, rd); check("abort_status", rd, 32'h0000_0002);
        wb_wr(A_TX, 32'h7E);
        ss_low();
        spi_byte(8'h81, 8, 1'b0, mi); check("post_abort_miso", 32'(mi), 32'h0000_007E);
        ss_high();
        wb_access(A_STAT, 1'b0, 32'h0, rd); check("post_abort_status", rd, 32'h0000_000B);
        wb_access(A_RX, 1'b0, 32'h0, rd);   check("post_abort_rx", rd, 32'h0000_0081);
        wb_wr(A_STAT, 32'h8);

        // Receive interrupt timing
        wb_wr(A_CTRL, 32'h3);
        wb_wr(A_TX, 32'h55);
        ss_low();
        spi_byte(8'hE7, 8, 1'b0, mi); check("rxie_miso", 32'(mi), 32'h0000_0055);
        check("rxie_intr_at3", 32'(intr_n3), 32'd0);
        check("rxie_intr_at4", 32'(intr_n4), 32'd1);
        ss_high();
        check("rxie_intr_held", 32'(intr), 32'd1);
        wb_access(A_RX, 1'b0, 32'h0, rd); check("rxie_rx", rd, 32'h0000_00E7);
        check("rxie_intr_during_ack", 32'(intr_at_ack), 32'd1);
        check("rxie_intr_cleared", 32'(intr), 32'd0);
        wb_wr(A_STAT, 32'h8);

        // Transmit interrupt while selected with an empty buffer
        wb_wr(A_CTRL, 32'h5);
        check("txie_unselected", 32'(intr), 32'd0);
        ss_low();
        check("txie_selected", 32'(intr), 32'd1);
        wb_wr(A_TX, 32'h99);
        check("txie_refilled", 32'(intr), 32'd0);
        ss_high();

        // Collision: RXDATA read ack on the capture cycle
        wb_wr(A_CTRL, 32'h1);
        wb_wr(A_STAT, 32'h8);
        ss_low();
        spi_byte(8'h44, 8, 1'b0, mi); check("coll_miso0", 32'(mi), 32'h0000_0099);
        spi_byte(8'h66, 8, 1'b1, mi); check("coll_miso1", 32'(mi), 32'h0000_0000);
        check("coll_ack", 32'(coll_ack), 32'd1);
        check("coll_old_data", coll_dat, 32'h0000_0044);
        wb_access(A_STAT, 1'b0, 32'h0, rd); check("coll_status", rd, 32'h0000_001B);
        ss_high();
        wb_access(A_RX, 1'b0, 32'h0, rd); check("coll_rx", rd, 32'h0000_0066);
        check("final_intr", 32'(intr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
